// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

   // FSM state encoding (kept as plain constants for legacy tools)
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_OWN_A = 2'b01;
   localparam logic [1:0] ST_OWN_B = 2'b10;

   // Owner IDs; these double as the mux select value for that owner
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   // Ownership state that belongs to a given owner ID
   function automatic logic [1:0] own_state(input logic owner);
      return (owner == OWNER_B) ? ST_OWN_B : ST_OWN_A;
   endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant bundle between the two requesters and the arbiter.
interface mux2_rr_arbiter_if #(
   parameter int unsigned CW = 8
);
   logic          req_a;
   logic          req_b;
   logic          gnt_a;
   logic          gnt_b;
   logic          sel;
   logic          busy;
   logic [CW-1:0] hold_cnt;

   // Requester side
   modport master (
      output req_a, req_b,
      input  gnt_a, gnt_b, sel, busy, hold_cnt
   );

   // Arbiter side
   modport slave (
      input  req_a, req_b,
      output gnt_a, gnt_b, sel, busy, hold_cnt
   );
endinterface

// File: rtl/mux2_rr_arbiter_hold_counter.sv
// Saturating hold counter: clear wins over enable, stops at limit_i.
module arb_hold_counter #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [CW-1:0] limit_i,
   output logic [CW-1:0] cnt_o,
   output logic          at_limit_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   assign at_limit_o = (cnt_q == limit_i);
   assign cnt_o      = cnt_q;

   // Next count: clear, count up, or hold once the limit is reached
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !at_limit_o)
         cnt_d = cnt_q + CW'(1);
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mux2_rr_arbiter_sys.sv
// Arbiter plus the shared mux it controls; sel is wired straight through.
module mux2_rr_arbiter_sys #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CW       = 8,
   parameter int unsigned W        = 1
) (
   input  logic             clk,
   input  logic             reset,
   mux2_rr_arbiter_if.slave arb,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   output logic [W-1:0]     out_o
);
   mux2_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) u_arb (
      .clk   (clk),
      .reset (reset),
      .bus   (arb)
   );

   student_mux #(.W(W)) u_mux (
      .a   (a_i),
      .b   (b_i),
      .sel (arb.sel),
      .out (out_o)
   );
endmodule

// File: rtl/student_mux.sv
// Plain 2:1 mux: sel=0 routes a, sel=1 routes b.
module student_mux #(
   parameter int unsigned W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] out
);
   assign out = sel ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux.
// Grants are registered; a grant is held while requested, but only for
// MAX_HOLD cycles when the other side is also waiting.
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CW       = 8
) (
   input  logic              clk,
   input  logic              reset,
   mux2_rr_arbiter_if.slave  bus
);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

   logic [1:0]    state_q, state_d;
   logic          gnt_a_q, gnt_a_d;
   logic          gnt_b_q, gnt_b_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic          entering;
   logic          hold_clr, hold_en, at_limit;
   logic [CW-1:0] hold_cnt;

   // Next owner selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_a && bus.req_b)
               state_d = own_state(~last_q);   // tie goes opposite last owner
            else if (bus.req_a)
               state_d = ST_OWN_A;
            else if (bus.req_b)
               state_d = ST_OWN_B;
         end
         ST_OWN_A: begin
            if (!bus.req_a)
               state_d = bus.req_b ? ST_OWN_B : ST_IDLE;  // no idle bubble
            else if (bus.req_b && at_limit)
               state_d = ST_OWN_B;
         end
         ST_OWN_B: begin
            if (!bus.req_b)
               state_d = bus.req_a ? ST_OWN_A : ST_IDLE;
            else if (bus.req_a && at_limit)
               state_d = ST_OWN_A;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Grant, select and last-owner updates derived from the next state
   always_comb begin
      entering = (state_d != state_q) && (state_d != ST_IDLE);
      gnt_a_d  = (state_d == ST_OWN_A);
      gnt_b_d  = (state_d == ST_OWN_B);
      sel_d    = sel_q;     // sel holds in IDLE so the mux never flips early
      last_d   = last_q;
      if (entering) begin
         sel_d  = (state_d == ST_OWN_B) ? OWNER_B : OWNER_A;
         last_d = sel_d;
      end
      hold_clr = (state_d != state_q);
      hold_en  = (state_d == state_q) && (state_q != ST_IDLE);
   end

   // State and grant registers; last owner resets to B so A wins first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         sel_q   <= OWNER_A;
         last_q  <= OWNER_B;
      end else begin
         state_q <= state_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

   arb_hold_counter #(.CW(CW)) u_hold (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (hold_clr),
      .en_i       (hold_en),
      .limit_i    (LIMIT),
      .cnt_o      (hold_cnt),
      .at_limit_o (at_limit)
   );

   assign bus.gnt_a    = gnt_a_q;
   assign bus.gnt_b    = gnt_b_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = gnt_a_q | gnt_b_q;
   assign bus.hold_cnt = hold_cnt;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: vector table through a scoreboard queue, plus
// async-reset and MAX_HOLD=1 end-to-end sequences.
module tb_mux2_rr_arbiter;
   typedef struct {
      logic       do_rst;
      logic       ra, rb;
      logic       ga, gb, sel;
      logic [7:0] hold;
   } vec_t;

   logic clk, reset, rst1;
   logic a1, b1, out1;
   int   checks, failures;
   vec_t vecs[30];
   vec_t exp_q[$];

   mux2_rr_arbiter_if #(.CW(8)) bus ();
   mux2_rr_arbiter_if #(.CW(8)) bus1 ();

   mux2_rr_arbiter #(.MAX_HOLD(4), .CW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mux2_rr_arbiter_sys #(.MAX_HOLD(1), .CW(8), .W(1)) sys (
      .clk   (clk),
      .reset (rst1),
      .arb   (bus1),
      .a_i   (a1),
      .b_i   (b1),
      .out_o (out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic ra, input logic rb,
                               input logic ga, input logic gb, input logic s,
                               input int h);
      vec_t v;
      v.do_rst = r; v.ra = ra; v.rb = rb;
      v.ga = ga; v.gb = gb; v.sel = s; v.hold = 8'(h);
      return v;
   endfunction

   // Pulse reset across one edge; returns on a falling edge
   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vec_t e;
      checks = 0; failures = 0;
      reset = 1'b1; rst1 = 1'b1;
      bus.req_a = 1'b0; bus.req_b = 1'b0;
      bus1.req_a = 1'b0; bus1.req_b = 1'b0;
      a1 = 1'b1; b1 = 1'b0;

      // Only A requesting: grant from first edge, hold saturates at 3
      vecs[0]  = mk(1, 1,0, 1,0,0, 0);
      vecs[1]  = mk(0, 1,0, 1,0,0, 1);
      vecs[2]  = mk(0, 1,0, 1,0,0, 2);
      vecs[3]  = mk(0, 1,0, 1,0,0, 3);
      vecs[4]  = mk(0, 1,0, 1,0,0, 3);
      vecs[5]  = mk(0, 1,0, 1,0,0, 3);
      vecs[6]  = mk(0, 0,0, 0,0,0, 0);
      // Both requesting from reset: A x4, B x4, A x4
      for (int k = 0; k < 12; k++)
         vecs[7+k] = mk(k == 0, 1,1, (k/4) != 1, (k/4) == 1, (k/4) == 1, k % 4);
      // A drops while B waits: direct handover
      vecs[19] = mk(0, 0,1, 0,1,1, 0);
      vecs[20] = mk(0, 0,1, 0,1,1, 1);
      // B drops, nobody waiting: IDLE keeps sel=1
      vecs[21] = mk(0, 0,0, 0,0,1, 0);
      vecs[22] = mk(0, 0,0, 0,0,1, 0);
      vecs[23] = mk(0, 1,0, 1,0,0, 0);
      vecs[24] = mk(0, 0,0, 0,0,0, 0);
      // Tie from IDLE after A owned: B wins
      vecs[25] = mk(0, 1,1, 0,1,1, 0);
      vecs[26] = mk(0, 1,1, 0,1,1, 1);
      // A drops and re-raises while B holds; B forced off at limit
      vecs[27] = mk(0, 0,1, 0,1,1, 2);
      vecs[28] = mk(0, 1,1, 0,1,1, 3);
      vecs[29] = mk(0, 1,1, 1,0,0, 0);

      // Reset state
      @(negedge clk);
      chk("rst gnt_a", 32'(bus.gnt_a), 0);
      chk("rst gnt_b", 32'(bus.gnt_b), 0);
      chk("rst sel", 32'(bus.sel), 0);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst hold", 32'(bus.hold_cnt), 0);
      reset = 1'b0;

      for (int i = 0; i < 30; i++) begin
         if (vecs[i].do_rst) apply_reset();
         else @(negedge clk);
         bus.req_a = vecs[i].ra;
         bus.req_b = vecs[i].rb;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("v%0d gnt_a", i), 32'(bus.gnt_a), 32'(e.ga));
         chk($sformatf("v%0d gnt_b", i), 32'(bus.gnt_b), 32'(e.gb));
         chk($sformatf("v%0d sel", i), 32'(bus.sel), 32'(e.sel));
         chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(e.ga | e.gb));
         chk($sformatf("v%0d hold", i), 32'(bus.hold_cnt), 32'(e.hold));
      end

      // Async reset while B owns
      apply_reset();
      bus.req_b = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("ar pre gnt_b", 32'(bus.gnt_b), 1);
      chk("ar pre hold", 32'(bus.hold_cnt), 1);
      #2 reset = 1'b1;
      #1;
      chk("ar gnt_b", 32'(bus.gnt_b), 0);
      chk("ar busy", 32'(bus.busy), 0);
      chk("ar sel", 32'(bus.sel), 0);
      chk("ar hold", 32'(bus.hold_cnt), 0);
      @(negedge clk);
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ar post gnt_a", 32'(bus.gnt_a), 1);
      chk("ar post gnt_b", 32'(bus.gnt_b), 0);
      chk("ar post sel", 32'(bus.sel), 0);

      // MAX_HOLD=1 through the mux: a=1, b=0, alternate every cycle
      @(negedge clk);
      rst1 = 1'b0;
      bus1.req_a = 1'b1; bus1.req_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(mk(0, 1,1, (k % 2) == 0, (k % 2) == 1, (k % 2) == 1, 0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         chk($sformatf("mh1 c%0d gnt_a", k), 32'(bus1.gnt_a), 32'(e.ga));
         chk($sformatf("mh1 c%0d gnt_b", k), 32'(bus1.gnt_b), 32'(e.gb));
         chk($sformatf("mh1 c%0d sel", k), 32'(bus1.sel), 32'(e.sel));
         chk($sformatf("mh1 c%0d out", k), 32'(out1), (k % 2 == 0) ? 32'd1 : 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
